oci_trace_capture_buffer: RTL and testbench

Parametrised on-chip-instrumentation trace capture block for the soft-CPU debug path.
- Captures each debug-trace (DCT) word (payload plus its frame count) into a circular buffer of DEPTH entries.
- On test end, drains the capture through a valid/ready read port so a bench monitor or debug-bus bridge can dump it.
- Successor to the fixed 30-bit/4-bit OCI test-bench hook: adds configurable width, depth, wrap mode, backpressure and status.

---
 rtl/oci_trace_capture_buffer_if.sv | 23 ++
 rtl/oci_trace_capture_buffer.sv | 110 +++++++++++
 tb/tb_oci_trace_capture_buffer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/oci_trace_capture_buffer_if.sv
// Trace capture bus: DCT word input plus the valid/ready drain port.
// The buffer takes the slave side; whoever feeds and dumps it takes the master side.
interface oci_trace_capture_buffer_if #(
   parameter int DATA_W = 30,
   parameter int CNT_W  = 4
);
   logic [DATA_W-1:0]       dct_buffer;
   logic [CNT_W-1:0]        dct_count;
   logic                    dct_valid;
   logic [DATA_W+CNT_W-1:0] rd_data;
   logic                    rd_valid;
   logic                    rd_ready;

   modport master (
      output dct_buffer, dct_count, dct_valid, rd_ready,
      input  rd_data, rd_valid
   );

   modport slave (
      input  dct_buffer, dct_count, dct_valid, rd_ready,
      output rd_data, rd_valid
   );
endinterface

// File: rtl/oci_trace_capture_buffer.sv
// Circular capture buffer for soft-CPU debug trace words.
// Fills during CAPTURE, drains show-ahead during DRAIN, then parks in DONE until reset.
module oci_trace_capture_buffer #(
   parameter int DATA_W    = 30,
   parameter int CNT_W     = 4,
   parameter int DEPTH     = 16,
   parameter int ADDR_W    = 4,
   parameter int WRAP_MODE = 0
) (
   input  logic                          clk,
   input  logic                          reset_n,
   oci_trace_capture_buffer_if.slave     bus,
   input  logic                          test_ending,
   input  logic                          test_has_ended,
   output logic [ADDR_W:0]               fill_level,
   output logic                          overflow,
   output logic                          done
);

   typedef enum logic [1:0] {CAPTURE, DRAIN, FINISHED} state_t;

   localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);

   state_t                  state, state_next;
   logic [DATA_W+CNT_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0]       wr_ptr, rd_ptr;
   logic                    full, empty;
   logic                    wr_en, pop, ovf_event;

   assign full  = (fill_level == FULL_LEVEL);
   assign empty = (fill_level == '0);

   // An abort wins over everything else, so no write or pop happens in that cycle.
   always_comb begin
      wr_en     = 1'b0;
      pop       = 1'b0;
      ovf_event = 1'b0;
      if (!test_has_ended) begin
         if (state == CAPTURE && bus.dct_valid) begin
            wr_en     = !full || (WRAP_MODE != 0);
            ovf_event = full;
         end
         if (state == DRAIN && !empty && bus.rd_ready) begin
            pop = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= CAPTURE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (test_has_ended) begin
         state_next = FINISHED;
      end else begin
         case (state)
            CAPTURE:  if (test_ending) state_next = DRAIN;
            DRAIN:    if (empty) state_next = FINISHED;
            default:  state_next = FINISHED;
         endcase
      end
   end

   always_comb begin
      bus.rd_valid = (state == DRAIN) && !empty;
      bus.rd_data  = '0;
      done         = (state == FINISHED);
      if (bus.rd_valid) begin
         bus.rd_data = mem[rd_ptr];
      end
   end

   // A write into a full buffer in wrap mode drags rd_ptr along, so the oldest entry is lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_level <= '0;
         overflow   <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            if (full) begin
               rd_ptr <= rd_ptr + ADDR_W'(1);
            end else begin
               fill_level <= fill_level + (ADDR_W+1)'(1);
            end
         end else if (pop) begin
            rd_ptr     <= rd_ptr + ADDR_W'(1);
            fill_level <= fill_level - (ADDR_W+1)'(1);
         end
         if (ovf_event) begin
            overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= {bus.dct_count, bus.dct_buffer};
      end
   end

endmodule

// File: tb/tb_oci_trace_capture_buffer.sv
// Directed bench: dut0 runs stop-when-full, dut1 runs overwrite-oldest on the same stimulus.
module tb_oci_trace_capture_buffer;

   logic       clk;
   logic       reset_n;
   logic       test_ending;
   logic       test_has_ended;
   logic [4:0] fill0, fill1;
   logic       ovf0, ovf1;
   logic       done0, done1;
   int         checks;
   int         errors;

   oci_trace_capture_buffer_if #(.DATA_W(30), .CNT_W(4)) bus0 ();
   oci_trace_capture_buffer_if #(.DATA_W(30), .CNT_W(4)) bus1 ();

   assign bus1.dct_buffer = bus0.dct_buffer;
   assign bus1.dct_count  = bus0.dct_count;
   assign bus1.dct_valid  = bus0.dct_valid;
   assign bus1.rd_ready   = bus0.rd_ready;

   oci_trace_capture_buffer #(.DATA_W(30), .CNT_W(4), .DEPTH(16), .ADDR_W(4), .WRAP_MODE(0)) dut0 (
      .clk            (clk),
      .reset_n        (reset_n),
      .bus            (bus0),
      .test_ending    (test_ending),
      .test_has_ended (test_has_ended),
      .fill_level     (fill0),
      .overflow       (ovf0),
      .done           (done0)
   );

   oci_trace_capture_buffer #(.DATA_W(30), .CNT_W(4), .DEPTH(16), .ADDR_W(4), .WRAP_MODE(1)) dut1 (
      .clk            (clk),
      .reset_n        (reset_n),
      .bus            (bus1),
      .test_ending    (test_ending),
      .test_has_ended (test_has_ended),
      .fill_level     (fill1),
      .overflow       (ovf1),
      .done           (done1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] word(input logic [3:0] cnt, input logic [29:0] payload);
      return {30'b0, cnt, payload};
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Inputs change one time unit after the edge, so outputs are sampled well away from it.
   task automatic applyStimulus(input logic valid, input logic [29:0] payload, input logic [3:0] cnt,
                                input logic ending, input logic has_ended, input logic ready);
      bus0.dct_valid  = valid;
      bus0.dct_buffer = payload;
      bus0.dct_count  = cnt;
      test_ending     = ending;
      test_has_ended  = has_ended;
      bus0.rd_ready   = ready;
      @(posedge clk);
      #1;
   endtask

   task automatic resetDut();
      bus0.dct_valid  = 1'b0;
      bus0.dct_buffer = '0;
      bus0.dct_count  = '0;
      bus0.rd_ready   = 1'b0;
      test_ending     = 1'b0;
      test_has_ended  = 1'b0;
      reset_n         = 1'b0;
      #2;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [6:0] ready_pattern;
      int         idx;
      checks = 0;
      errors = 0;
      reset_n         = 1'b0;
      bus0.dct_valid  = 1'b0;
      bus0.dct_buffer = '0;
      bus0.dct_count  = '0;
      bus0.rd_ready   = 1'b0;
      test_ending     = 1'b0;
      test_has_ended  = 1'b0;

      #1;
      checkOutput("rst_fill", 64'(fill0), 64'd0);
      checkOutput("rst_rd_valid", 64'(bus0.rd_valid), 64'd0);
      checkOutput("rst_rd_data", 64'(bus0.rd_data), 64'd0);
      checkOutput("rst_done", 64'(done0), 64'd0);
      checkOutput("rst_overflow", 64'(ovf0), 64'd0);
      #2;
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] basic capture and drain");
      applyStimulus(1, 30'h1, 4'h1, 0, 0, 0);
      applyStimulus(1, 30'h2, 4'h2, 0, 0, 0);
      applyStimulus(1, 30'h3, 4'h3, 0, 0, 0);
      checkOutput("t1_fill3", 64'(fill0), 64'd3);
      checkOutput("t1_no_rd_valid_capture", 64'(bus0.rd_valid), 64'd0);
      applyStimulus(0, 0, 0, 1, 0, 1);
      checkOutput("t1_rd_valid", 64'(bus0.rd_valid), 64'd1);
      checkOutput("t1_word1", 64'(bus0.rd_data), word(4'h1, 30'h1));
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("t1_word2", 64'(bus0.rd_data), word(4'h2, 30'h2));
      checkOutput("t1_fill2", 64'(fill0), 64'd2);
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("t1_word3", 64'(bus0.rd_data), word(4'h3, 30'h3));
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("t1_fill0", 64'(fill0), 64'd0);
      checkOutput("t1_rd_valid_low", 64'(bus0.rd_valid), 64'd0);
      checkOutput("t1_not_done_yet", 64'(done0), 64'd0);
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("t1_done", 64'(done0), 64'd1);
      checkOutput("t1_overflow", 64'(ovf0), 64'd0);

      $display("[TB] overflow: stop-when-full vs overwrite-oldest");
      resetDut();
      for (int i = 0; i < 16; i++) applyStimulus(1, 30'(i), 4'(i), 0, 0, 0);
      checkOutput("t2_full_fill", 64'(fill0), 64'd16);
      checkOutput("t2_full_no_ovf", 64'(ovf0), 64'd0);
      checkOutput("t3_full_no_ovf", 64'(ovf1), 64'd0);
      for (int i = 16; i < 20; i++) applyStimulus(1, 30'(i), 4'(i), 0, 0, 0);
      checkOutput("t2_fill", 64'(fill0), 64'd16);
      checkOutput("t2_ovf", 64'(ovf0), 64'd1);
      checkOutput("t3_fill", 64'(fill1), 64'd16);
      checkOutput("t3_ovf", 64'(ovf1), 64'd1);
      applyStimulus(0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 16; i++) begin
         checkOutput($sformatf("t2_drain%0d", i), 64'(bus0.rd_data), word(4'(i), 30'(i)));
         checkOutput($sformatf("t3_drain%0d", i), 64'(bus1.rd_data), word(4'(i + 4), 30'(i + 4)));
         applyStimulus(0, 0, 0, 0, 0, 1);
      end
      checkOutput("t2_empty", 64'(bus0.rd_valid), 64'd0);
      checkOutput("t3_empty", 64'(bus1.rd_valid), 64'd0);
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("t2_done", 64'(done0), 64'd1);
      checkOutput("t3_done", 64'(done1), 64'd1);

      $display("[TB] backpressure");
      resetDut();
      for (int i = 0; i < 4; i++) applyStimulus(1, 30'(32'h100 + i), 4'(i + 1), 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 0, 0);
      ready_pattern = 7'b1101001;
      idx = 0;
      for (int k = 0; k < 7; k++) begin
         checkOutput($sformatf("t4_rd_valid%0d", k), 64'(bus0.rd_valid), 64'(idx < 4));
         if (idx < 4)
            checkOutput($sformatf("t4_data%0d", k), 64'(bus0.rd_data), word(4'(idx + 1), 30'(32'h100 + idx)));
         applyStimulus(0, 0, 0, 0, 0, ready_pattern[k]);
         if (ready_pattern[k] && idx < 4) idx++;
      end
      checkOutput("t4_pops", 64'(idx), 64'd4);
      checkOutput("t4_fill0", 64'(fill0), 64'd0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("t4_done", 64'(done0), 64'd1);

      $display("[TB] test_ending together with dct_valid");
      resetDut();
      applyStimulus(1, 30'h21, 4'h1, 0, 0, 0);
      applyStimulus(1, 30'h22, 4'h2, 0, 0, 0);
      applyStimulus(1, 30'h23, 4'h3, 1, 0, 0);
      checkOutput("t5a_fill", 64'(fill0), 64'd3);
      checkOutput("t5a_first", 64'(bus0.rd_data), word(4'h1, 30'h21));
      applyStimulus(0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("t5a_last", 64'(bus0.rd_data), word(4'h3, 30'h23));
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("t5a_drained", 64'(bus0.rd_valid), 64'd0);

      $display("[TB] abort mid-drain");
      resetDut();
      for (int i = 0; i < 5; i++) applyStimulus(1, 30'(32'h50 + i), 4'(i), 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 0, 0);
      checkOutput("t5b_word0", 64'(bus0.rd_data), word(4'h0, 30'h50));
      applyStimulus(0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("t5b_word2", 64'(bus0.rd_data), word(4'h2, 30'h52));
      checkOutput("t5b_fill3", 64'(fill0), 64'd3);
      applyStimulus(0, 0, 0, 0, 1, 1);
      checkOutput("t5b_done", 64'(done0), 64'd1);
      checkOutput("t5b_rd_valid", 64'(bus0.rd_valid), 64'd0);
      checkOutput("t5b_fill_frozen", 64'(fill0), 64'd3);
      applyStimulus(1, 30'h7, 4'h7, 1, 0, 1);
      checkOutput("t5b_still_done", 64'(done0), 64'd1);
      checkOutput("t5b_still_fill3", 64'(fill0), 64'd3);

      $display("[TB] empty drain");
      resetDut();
      applyStimulus(0, 0, 0, 1, 0, 0);
      checkOutput("t6a_not_done", 64'(done0), 64'd0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("t6a_done", 64'(done0), 64'd1);

      $display("[TB] asynchronous reset mid-drain");
      resetDut();
      for (int i = 0; i < 17; i++) applyStimulus(1, 30'(i), 4'(i), 0, 0, 0);
      checkOutput("t6b_ovf_set", 64'(ovf0), 64'd1);
      applyStimulus(0, 0, 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("t6b_draining", 64'(bus0.rd_valid), 64'd1);
      #3;
      reset_n = 1'b0;
      #1;
      checkOutput("t6b_rd_valid", 64'(bus0.rd_valid), 64'd0);
      checkOutput("t6b_done", 64'(done0), 64'd0);
      checkOutput("t6b_fill", 64'(fill0), 64'd0);
      checkOutput("t6b_ovf", 64'(ovf0), 64'd0);
      checkOutput("t6b_rd_data", 64'(bus0.rd_data), 64'd0);
      #1;
      reset_n = 1'b1;
      applyStimulus(1, 30'h2AB, 4'h5, 0, 0, 0);
      checkOutput("t6b_refill", 64'(fill0), 64'd1);
      applyStimulus(0, 0, 0, 1, 0, 0);
      checkOutput("t6b_first_word", 64'(bus0.rd_data), word(4'h5, 30'h2AB));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
